router_fsm: RTL and testbench
=============================

// Module: router_fsm
// PURPOSE
//  Control FSM of the 1x3 packet router. Watches the incoming header (2-bit address), the
//  per-port FIFO empty/full flags and the register block's parity/short-packet flags.
//  Drives load strobes to the register block, write enable to the FIFOs, and busy back
//  to the source. Sits between the input register block and the three output FIFOs.
// PARAMETERS
//  None. State encodings are localparams imported from router_pkg.
// PORTS
//  clock             in  1  system clock; all state changes on posedge
//  resetn            in  1  asynchronous, active-low reset
//  pkt_valid         in  1  source is presenting packet bytes
//  data_in           in  2  header address bits [1:0]; 0/1/2 = port, 3 = invalid
//  fifo_full         in  1  full flag of the currently addressed FIFO
//  fifo_empty_0..2   in  1  empty flag of FIFO 0/1/2
//  soft_reset_0..2   in  1  timeout soft reset from FIFO 0/1/2
//  parity_done       in  1  parity byte captured by the register block
//  low_packet_valid  in  1  pkt_valid fell while a byte was held in the full-state register
//  write_enb_reg     out 1  FIFO write enable
//  detect_add        out 1  in DECODE_ADDRESS
//  ld_state          out 1  in LOAD_DATA
//  laf_state         out 1  in LOAD_AFTER_FULL
//  lfd_state         out 1  in LOAD_FIRST_DATA
//  full_state        out 1  in FIFO_FULL_STATE
//  rst_int_reg       out 1  in CHECK_PARITY_ERROR; clears internal parity registers
//  busy              out 1  router cannot accept a new byte
// BEHAVIOUR
//  - State register is named `state`, 3 bits. Encoding: DA=0 (DECODE_ADDRESS), LFD=1,
//    LD=2, LP=3 (LOAD_PARITY), CPE=4 (CHECK_PARITY_ERROR), FFS=5, LAF=6, WTE=7 (WAIT_TILL_EMPTY).
//  - resetn=0 forces state to DA immediately, without waiting for a clock edge.
//  - While in reset: detect_add=1, all other outputs 0. The address latch resets to 0.
//  - Address latch: in DA with pkt_valid=1, capture data_in on the clock edge.
//  - Transitions, evaluated each posedge:
//    DA : pkt_valid & data_in==k (k<3) & fifo_empty_k  -> LFD
//         pkt_valid & data_in==k (k<3) & !fifo_empty_k -> WTE
//         otherwise (including data_in==3)             -> DA
//    LFD: -> LD unconditionally (one cycle)
//    LD : fifo_full -> FFS; else !pkt_valid -> LP; else stay in LD
//    FFS: !fifo_full -> LAF; else stay in FFS
//    LAF: parity_done -> DA; else low_packet_valid -> LP; else -> LD
//    LP : -> CPE unconditionally
//    CPE: fifo_full -> FFS; else -> DA
//    WTE: fifo_empty[latched addr] -> LFD; else stay in WTE
//  - Outputs are combinational (Moore) from state:
//    detect_add = DA; lfd_state = LFD; ld_state = LD; laf_state = LAF; full_state = FFS
//    write_enb_reg = LD | LP | LAF
//    rst_int_reg = CPE
//    busy = LFD | LP | CPE | FFS | LAF | WTE (busy=0 only in DA and LD)
//  - Simultaneous inputs: fifo_full has priority over !pkt_valid in LD.
//    parity_done has priority over low_packet_valid in LAF.
// CONFIGURATION
//  ROUTER_FSM_SOFT_RESET_EN defined:
//    - soft_reset_k=1 with latched addr==k forces DA on the next posedge.
//    - This overrides every transition (async resetn still dominates).
//  ROUTER_FSM_SOFT_RESET_EN undefined: soft_reset_0..2 are ignored.
// STRUCTURE
//  - router_pkg: state localparams (DA..WTE), port-address constants ADDR_P0..ADDR_P2 and
//    ADDR_INVALID=2'd3.
//  - Single flat module: state register, address latch, next-state logic, output decode.
//    No sub-module is needed.
// TESTING
//  Clock period 20 time units; drive stimulus on negedge.
//  1. Clean packet: pkt_valid=1, data_in=0, fifo_empty_0=1; drop pkt_valid after 2 cycles.
//     -> state 0,1,2,3,4,0; busy=1 in LFD/LP/CPE; rst_int_reg=1 for exactly one cycle.
//  2. Full mid-packet: in LD set fifo_full=1, then 0, then low_packet_valid=1.
//     -> state 2,5,6,3,4,0; full_state then laf_state each asserted for one cycle.
//  3. Full after parity: as test 1, but fifo_full=1 in CPE, then fifo_full=0, then parity_done=1.
//     -> state 3,4,5,6,0.
//  4. Busy destination: data_in=1, fifo_empty_1=0 -> WTE with busy=1 and write_enb_reg=0.
//     Set fifo_empty_1=1 -> LFD, then LD.
//  5. Invalid address: data_in=3, pkt_valid=1 -> stays in DA with detect_add=1.
//  6. resetn=0 mid-LD, asserted between clock edges -> DA immediately.
//     With ROUTER_FSM_SOFT_RESET_EN: soft_reset_0=1 in FFS -> DA at the next posedge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 packet router control path: FSM state
// encodings, header address constants, and a helper that picks one of
// three per-port flags by address.
package router_pkg;

  typedef enum logic [2:0] {
    DA  = 3'd0,  // DECODE_ADDRESS
    LFD = 3'd1,  // LOAD_FIRST_DATA
    LD  = 3'd2,  // LOAD_DATA
    LP  = 3'd3,  // LOAD_PARITY
    CPE = 3'd4,  // CHECK_PARITY_ERROR
    FFS = 3'd5,  // FIFO_FULL_STATE
    LAF = 3'd6,  // LOAD_AFTER_FULL
    WTE = 3'd7   // WAIT_TILL_EMPTY
  } state_t;

  localparam logic [1:0] ADDR_P0      = 2'd0;
  localparam logic [1:0] ADDR_P1      = 2'd1;
  localparam logic [1:0] ADDR_P2      = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  // Select the flag belonging to the addressed port; the invalid address
  // never selects a port, so it reads as 0.
  function automatic logic sel_port_flag(input logic [1:0] addr,
                                         input logic [2:0] flags);
    case (addr)
      ADDR_P0:      return flags[0];
      ADDR_P1:      return flags[1];
      ADDR_P2:      return flags[2];
      ADDR_INVALID: return 1'b0;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router. Decodes the header address, steers
// the register block through its load phases, enables FIFO writes and
// raises busy toward the source whenever a byte cannot be accepted.
// Optional feature: define ROUTER_FSM_SOFT_RESET_EN to let a FIFO timeout
// soft reset on the latched destination port abort the packet back to DA.
import router_pkg::*;

module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  state_t     state;
  state_t     next_state;
  logic [1:0] addr_q;
  logic [2:0] empty_vec;
  logic       hdr_valid;
  logic       hdr_empty;
  logic       latched_empty;
  logic       soft_hit;

  assign empty_vec     = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign hdr_valid     = pkt_valid && (data_in != ADDR_INVALID);
  assign hdr_empty     = sel_port_flag(data_in, empty_vec);
  assign latched_empty = sel_port_flag(addr_q, empty_vec);

`ifdef ROUTER_FSM_SOFT_RESET_EN
  // Only the port this packet is headed for may abort it.
  assign soft_hit = sel_port_flag(addr_q, {soft_reset_2, soft_reset_1, soft_reset_0});
`else
  logic unused_soft_reset;
  assign unused_soft_reset = ^{soft_reset_0, soft_reset_1, soft_reset_2};
  assign soft_hit          = 1'b0;
`endif

  // State register; resetn returns to DA without waiting for a clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation order cannot change the result.
    if (!resetn) state <= DA;
    else         state <= next_state;
  end

  // Destination latch: remembers the header address while the packet (or the
  // wait for its FIFO to drain) is in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                      addr_q <= ADDR_P0;
    else if (state == DA && pkt_valid) addr_q <= data_in;
  end

  // Next-state logic; the soft reset override is applied last so it wins.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred when a branch leaves next_state untouched.
    next_state = state;
    case (state)
      DA: begin
        if (hdr_valid) next_state = hdr_empty ? LFD : WTE;
      end
      LFD: next_state = LD;
      LD: begin
        if (fifo_full)       next_state = FFS;
        else if (!pkt_valid) next_state = LP;
      end
      FFS: begin
        if (!fifo_full) next_state = LAF;
      end
      LAF: begin
        if (parity_done)           next_state = DA;
        else if (low_packet_valid) next_state = LP;
        else                       next_state = LD;
      end
      LP:  next_state = CPE;
      CPE: next_state = fifo_full ? FFS : DA;
      WTE: begin
        if (latched_empty) next_state = LFD;
      end
      default: next_state = DA;
    endcase
    if (soft_hit) next_state = DA;
  end

  // Moore output decode straight from the current state.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (state)
      DA:  begin detect_add = 1'b1; busy = 1'b0; end
      LFD: lfd_state = 1'b1;
      LD:  begin ld_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b0; end
      LP:  write_enb_reg = 1'b1;
      CPE: rst_int_reg = 1'b1;
      FFS: full_state = 1'b1;
      LAF: begin laf_state = 1'b1; write_enb_reg = 1'b1; end
      WTE: busy = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks the packet flows, the full-FIFO
// detours, the busy-destination wait, the invalid header, async reset and
// the optional soft reset, comparing state and all outputs each cycle.
module tb_router_fsm;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;
  logic       write_enb_reg, detect_add, ld_state, laf_state;
  logic       lfd_state, full_state, rst_int_reg, busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  logic [7:0] obs_out;
  logic [2:0] obs_state;
  assign obs_out   = {detect_add, lfd_state, ld_state, laf_state,
                      full_state, write_enb_reg, rst_int_reg, busy};
  assign obs_state = dut.state;

  router_fsm dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .fifo_empty_0     (fifo_empty_0),
    .fifo_empty_1     (fifo_empty_1),
    .fifo_empty_2     (fifo_empty_2),
    .soft_reset_0     (soft_reset_0),
    .soft_reset_1     (soft_reset_1),
    .soft_reset_2     (soft_reset_2),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .write_enb_reg    (write_enb_reg),
    .detect_add       (detect_add),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .lfd_state        (lfd_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .busy             (busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [2:0] es, input logic [7:0] eo);
    n_assert++;
    assert (obs_state === es) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, obs_state, es);
    end
    n_assert++;
    assert (obs_out === eo) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs_out, eo);
    end
  endtask

  // One clock: sample #1 after posedge, then return at the next negedge
  // where the caller drives new inputs.
  task automatic step(input string tag, input logic [2:0] es, input logic [7:0] eo);
    @(posedge clock);
    #1;
    chk(tag, es, eo);
    @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_packet_valid = 1'b0;

    @(negedge clock);
    chk("reset", 3'd0, O_DA);
    resetn = 1'b1;

    // 1. Clean packet to port 0
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
    step("t1_lfd", 3'd1, O_LFD);
    step("t1_ld",  3'd2, O_LD);
    pkt_valid = 1'b0;
    step("t1_lp",  3'd3, O_LP);
    step("t1_cpe", 3'd4, O_CPE);
    step("t1_da",  3'd0, O_DA);

    // 2. Full mid-packet; fifo_full beats !pkt_valid in LD
    pkt_valid = 1'b1;
    step("t2_lfd", 3'd1, O_LFD);
    step("t2_ld",  3'd2, O_LD);
    pkt_valid = 1'b0; fifo_full = 1'b1;
    step("t2_ffs", 3'd5, O_FFS);
    fifo_full = 1'b0;
    step("t2_laf", 3'd6, O_LAF);
    low_packet_valid = 1'b1;
    step("t2_lp",  3'd3, O_LP);
    low_packet_valid = 1'b0;
    step("t2_cpe", 3'd4, O_CPE);
    step("t2_da",  3'd0, O_DA);

    // 3. Full after parity; parity_done beats low_packet_valid in LAF
    pkt_valid = 1'b1;
    step("t3_lfd", 3'd1, O_LFD);
    step("t3_ld",  3'd2, O_LD);
    pkt_valid = 1'b0;
    step("t3_lp",  3'd3, O_LP);
    step("t3_cpe", 3'd4, O_CPE);
    fifo_full = 1'b1;
    step("t3_ffs", 3'd5, O_FFS);
    fifo_full = 1'b0;
    step("t3_laf", 3'd6, O_LAF);
    parity_done = 1'b1; low_packet_valid = 1'b1;
    step("t3_da",  3'd0, O_DA);
    parity_done = 1'b0; low_packet_valid = 1'b0;

    // FFS hold, LAF fall-back to LD, then async reset between edges
    pkt_valid = 1'b1;
    step("t6_lfd", 3'd1, O_LFD);
    step("t6_ld",  3'd2, O_LD);
    fifo_full = 1'b1;
    step("t6_ffs",  3'd5, O_FFS);
    step("t6_ffs2", 3'd5, O_FFS);
    fifo_full = 1'b0;
    step("t6_laf", 3'd6, O_LAF);
    step("t6_ld2", 3'd2, O_LD);
    @(posedge clock);
    #5;
    resetn = 1'b0;
    #1;
    chk("t6_async_rst", 3'd0, O_DA);
    @(negedge clock);
    pkt_valid = 1'b0;
    resetn = 1'b1;

    // 4. Busy destination: wait on the latched port, not the current header
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b0;
    step("t4_wte", 3'd7, O_WTE);
    data_in = 2'd0; fifo_empty_0 = 1'b1;
    step("t4_wte2", 3'd7, O_WTE);
    fifo_empty_1 = 1'b1;
    step("t4_lfd", 3'd1, O_LFD);
    step("t4_ld",  3'd2, O_LD);
    pkt_valid = 1'b0;
    step("t4_lp",  3'd3, O_LP);
    step("t4_cpe", 3'd4, O_CPE);
    step("t4_da",  3'd0, O_DA);

    // 5. Invalid address stays in DA
    pkt_valid = 1'b1; data_in = 2'd3;
    step("t5_da",  3'd0, O_DA);
    step("t5_da2", 3'd0, O_DA);

    // Soft reset: only the latched port counts, and only when enabled
    data_in = 2'd0;
    step("sr_lfd", 3'd1, O_LFD);
    step("sr_ld",  3'd2, O_LD);
    fifo_full = 1'b1;
    step("sr_ffs", 3'd5, O_FFS);
    soft_reset_1 = 1'b1;
    step("sr_other_port", 3'd5, O_FFS);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
`ifdef ROUTER_FSM_SOFT_RESET_EN
    step("sr_abort", 3'd0, O_DA);
`else
    step("sr_ignored", 3'd5, O_FFS);
`endif
    soft_reset_0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
